elevator_group_ctrl: RTL

// - Parametrised group controller for N_CARS elevator cars serving N_FLOORS floors.
// - Registers hall calls per floor and direction and assigns each call to one car by a min-cost search.
// - Issues each assignment to its car over a valid/ack handshake and clears calls when a car reports arrival.
// - Generates a per-car parking floor from traffic_state; sits between the hall-button panel and the elevator_top instances.

---
 rtl/elev_pkg.sv | 8 +
 rtl/elev_cost_min.sv | 35 +++
 rtl/elevator_group_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/elev_pkg.sv
// elev_pkg: shared types for the elevator group controller
package elev_pkg;
  typedef enum logic [1:0] {NORMAL = 2'b00, UP_PEAK = 2'b01, DOWN_PEAK = 2'b10} traffic_e;
  typedef enum logic [2:0] {IDLE, SCAN, COST, ISSUE, WAIT_ACK} disp_state_e;
  typedef logic dir_t;
  localparam dir_t DIR_UP = 1'b1;
  localparam dir_t DIR_DN = 1'b0;
endpackage

// File: rtl/elev_cost_min.sv
// elev_cost_min: combinational min-cost car selection, one-hot result, lowest index wins ties
module elev_cost_min import elev_pkg::*; #(
  parameter int N_CARS = 2,
  parameter int FLOOR_W = 3,
  parameter int DIR_PENALTY = 4
) (
  input  logic [N_CARS*FLOOR_W-1:0] car_floor,
  input  logic [N_CARS-1:0]         car_dir,
  input  logic [N_CARS-1:0]         car_idle,
  input  logic [FLOOR_W-1:0]        call_floor,
  output logic [N_CARS-1:0]         win
);
  localparam int CW = FLOOR_W + $clog2(DIR_PENALTY + 1) + 1;
  logic [CW-1:0] cost, best;
  logic [FLOOR_W-1:0] f;
  logic away;
  // best starts above any reachable cost, so car 0 always seeds the search
  always_comb begin
    win = '0;
    best = '1;
    cost = '0;
    f = '0;
    away = 1'b0;
    for (int k = 0; k < N_CARS; k++) begin
      f = car_floor[k*FLOOR_W +: FLOOR_W];
      away = !car_idle[k] && (car_dir[k] == DIR_UP ? call_floor < f : call_floor > f);
      cost = CW'(f > call_floor ? f - call_floor : call_floor - f) + (away ? CW'(DIR_PENALTY) : '0);
      if (cost < best) begin
        best = cost;
        win = '0;
        win[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/elevator_group_ctrl.sv
// elevator_group_ctrl: hall-call registration, min-cost dispatch over valid/ack, parking floors
module elevator_group_ctrl import elev_pkg::*; #(
  parameter int N_CARS = 2,
  parameter int N_FLOORS = 7,
  parameter int DIR_PENALTY = 4,
  parameter int ACK_TIMEOUT = 16,
  localparam int FLOOR_W = $clog2(N_FLOORS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                traffic_state,
  input  logic                      hall_req_valid,
  input  logic [FLOOR_W-1:0]        hall_req_floor,
  input  logic                      hall_req_dir,
  output logic                      hall_req_err,
  input  logic [N_CARS*FLOOR_W-1:0] car_floor,
  input  logic [N_CARS-1:0]         car_dir,
  input  logic [N_CARS-1:0]         car_idle,
  input  logic [N_CARS-1:0]         car_arrive,
  output logic [N_CARS-1:0]         car_call_valid,
  output logic [FLOOR_W-1:0]        car_call_floor,
  input  logic [N_CARS-1:0]         car_call_ack,
  output logic [N_CARS*FLOOR_W-1:0] car_default_floor,
  output logic [N_FLOORS-1:0]       pending_up,
  output logic [N_FLOORS-1:0]       pending_dn
);
  localparam int NS = 2 * N_FLOORS;
  localparam int SW = $clog2(NS);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  // up slots occupy 0..N_FLOORS-1, down slots N_FLOORS..2*N_FLOORS-1
  function automatic logic [SW-1:0] slot_of(input logic [FLOOR_W-1:0] f, input dir_t d);
    return d == DIR_UP ? SW'(f) : SW'(f) + SW'(N_FLOORS);
  endfunction

  disp_state_e state, state_n;
  logic [NS-1:0] pending, assigned, avail, set, clr;
  logic [SW-1:0] ptr, sel, scan_idx, req_slot;
  logic scan_hit, req_ok, active, ack_hit, timeout;
  logic [TW-1:0] cnt;
  logic [FLOOR_W-1:0] sel_floor;
  logic [N_CARS-1:0] win;
  logic [N_CARS*FLOOR_W-1:0] park;

  assign pending_up = pending[N_FLOORS-1:0];
  assign pending_dn = pending[NS-1:N_FLOORS];
  assign avail = pending & ~assigned;
  assign req_slot = slot_of(hall_req_floor, hall_req_dir);
  assign req_ok = int'(hall_req_floor) < N_FLOORS
                  && !(hall_req_dir == DIR_UP && int'(hall_req_floor) == N_FLOORS - 1)
                  && !(hall_req_dir == DIR_DN && hall_req_floor == '0);
  assign active = state == ISSUE || state == WAIT_ACK;
  assign ack_hit = active && |(car_call_ack & car_call_valid);
  assign timeout = active && cnt == TW'(ACK_TIMEOUT - 1);
  assign sel_floor = FLOOR_W'(int'(sel) >= N_FLOORS ? int'(sel) - N_FLOORS : int'(sel));

  elev_cost_min #(.N_CARS(N_CARS), .FLOOR_W(FLOOR_W), .DIR_PENALTY(DIR_PENALTY)) u_cost (
    .car_floor (car_floor),
    .car_dir   (car_dir),
    .car_idle  (car_idle),
    .call_floor(sel_floor),
    .win       (win)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |avail ? SCAN : IDLE;
      SCAN:    state_n = scan_hit ? COST : IDLE;
      COST:    state_n = avail[sel] ? ISSUE : IDLE;
      default: state_n = ack_hit || timeout ? IDLE : WAIT_ACK;
    endcase
  end

  // descending loop so the slot nearest the round-robin pointer is written last
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = NS - 1; i >= 0; i--)
      if (avail[(int'(ptr) + i) % NS]) begin
        scan_hit = 1'b1;
        scan_idx = SW'((int'(ptr) + i) % NS);
      end
  end

  // a fresh call beats an arrival on the same slot
  always_comb begin
    clr = '0;
    set = '0;
    for (int k = 0; k < N_CARS; k++)
      if (car_arrive[k]) clr[slot_of(car_floor[k*FLOOR_W +: FLOOR_W], car_dir[k])] = 1'b1;
    if (hall_req_valid && req_ok) set[req_slot] = ~pending[req_slot] | clr[req_slot];
  end

  always_comb begin
    park = '0;
    for (int k = 0; k < N_CARS; k++)
      park[k*FLOOR_W +: FLOOR_W] = traffic_state == UP_PEAK ? '0 : FLOOR_W'(k * (N_FLOORS - 1) / (N_CARS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pending <= '0;
      assigned <= '0;
      ptr <= '0;
      sel <= '0;
      cnt <= '0;
      car_call_valid <= '0;
      car_call_floor <= '0;
      hall_req_err <= 1'b0;
      car_default_floor <= '0;
    end else begin
      state <= state_n;
      pending <= set | (pending & ~clr);
      assigned <= ~set & ~clr & (assigned | (ack_hit ? NS'(1) << sel : '0));
      hall_req_err <= hall_req_valid & ~req_ok;
      car_default_floor <= park;
      if (state == SCAN) sel <= scan_idx;
      if (state == COST && state_n == ISSUE) begin
        car_call_valid <= win;
        car_call_floor <= sel_floor;
        cnt <= '0;
        ptr <= int'(sel) == NS - 1 ? '0 : sel + SW'(1);
      end else if (ack_hit || timeout) car_call_valid <= '0;
      else if (active) cnt <= cnt + TW'(1);
    end
  end
endmodule
